// File: rtl/approx_eval_pkg.sv
// Shared types and helpers for the approximate-multiplier error sweeper.
package approx_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

  localparam int DEF_IN_W  = 4;
  localparam int DEF_OUT_W = 4;
  localparam int DEF_ET    = 5;

  typedef logic [DEF_OUT_W-1:0] err_t;

  function automatic int vec_count(input int in_w);
    return 32'sd1 << in_w;
  endfunction

endpackage

// File: rtl/approx_mul_err_sweeper_err_calc.sv
// Combinational error evaluator: exact product of the stimulus operands,
// absolute difference to the approximate output, and threshold violation.
module approx_err_calc #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 4,
  parameter int ET    = 5
) (
  input  logic [IN_W-1:0]  i_vec,
  input  logic [OUT_W-1:0] i_approx,
  output logic [OUT_W-1:0] o_exact,
  output logic [OUT_W-1:0] o_err,
  output logic             o_viol
);
  localparam int HALF_W = IN_W / 2;
  localparam logic [OUT_W-1:0] ET_V = OUT_W'(ET);

  logic [HALF_W-1:0] w_a;
  logic [HALF_W-1:0] w_b;
  logic [IN_W-1:0]   w_prod;

  assign w_a     = i_vec[HALF_W-1:0];
  assign w_b     = i_vec[IN_W-1:HALF_W];
  assign w_prod  = IN_W'(w_a) * IN_W'(w_b);
  assign o_exact = OUT_W'(w_prod);

  // Unsigned absolute difference, ordered so no wraparound occurs.
  always_comb begin
    o_err = '0;
    if (i_approx >= o_exact) begin
      o_err = i_approx - o_exact;
    end else begin
      o_err = o_exact - i_approx;
    end
  end

  assign o_viol = (o_err > ET_V);
endmodule

// File: rtl/approx_mul_err_sweeper.sv
// Sweeps every input vector through an approximate multiplier and collects
// max error, violation count and pass/fail. ERR_SUM_EN adds sum_err_o.
module approx_mul_err_sweeper
  import approx_eval_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int ET    = DEF_ET
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IN_W-1:0]  vec_o,
  input  logic [OUT_W-1:0] approx_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [OUT_W-1:0] max_err_o,
  output logic [IN_W:0]    viol_cnt_o,
  output logic             pass_o
`ifdef ERR_SUM_EN
  ,
  output logic [OUT_W+IN_W-1:0] sum_err_o
`endif
);
  localparam logic [IN_W-1:0] LAST_VEC = IN_W'(vec_count(IN_W) - 1);

  sweep_state_t r_state;
  sweep_state_t w_next;

  logic             r_issuing;
  logic [IN_W-1:0]  r_vec;
  logic             r_s1_valid;
  logic [IN_W-1:0]  r_s1_vec;
  logic [OUT_W-1:0] r_s1_approx;
  logic [OUT_W-1:0] r_max_err;
  logic [IN_W:0]    r_viol_cnt;
  logic             w_accept;
  logic [OUT_W-1:0] w_exact;
  logic [OUT_W-1:0] w_err;
  logic             w_viol;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

  approx_err_calc #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .ET    (ET)
  ) u_err_calc (
    .i_vec    (r_s1_vec),
    .i_approx (r_s1_approx),
    .o_exact  (w_exact),
    .o_err    (w_err),
    .o_viol   (w_viol)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: SWEEP ends once the last vector has been handed to stage 1.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? SWEEP : IDLE;
      SWEEP:   w_next = r_issuing ? SWEEP : DRAIN;
      DRAIN:   w_next = DONE;
      DONE:    w_next = w_accept ? SWEEP : DONE;
      default: w_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    pass_o = 1'b0;
    case (r_state)
      SWEEP:   busy_o = 1'b1;
      DRAIN:   busy_o = 1'b1;
      DONE: begin
        done_o = 1'b1;
        pass_o = (r_viol_cnt == '0);
      end
      default: busy_o = 1'b0;
    endcase
  end

  // Vector counter; holds at the last vector instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vec     <= '0;
      r_issuing <= 1'b0;
    end else if (w_accept) begin
      r_vec     <= '0;
      r_issuing <= 1'b1;
    end else if ((r_state == SWEEP) && r_issuing) begin
      if (r_vec == LAST_VEC) begin
        r_issuing <= 1'b0;
      end else begin
        r_vec <= r_vec + IN_W'(1);
      end
    end
  end

  assign vec_o = r_vec;

  // Stage 1: capture the stimulus together with the circuit's response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_vec    <= '0;
      r_s1_approx <= '0;
    end else begin
      r_s1_valid  <= (r_state == SWEEP) && r_issuing;
      r_s1_vec    <= r_vec;
      r_s1_approx <= approx_i;
    end
  end

  // Stage 2 accumulators; only valid stage-1 entries change them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_max_err  <= '0;
      r_viol_cnt <= '0;
    end else if (w_accept) begin
      r_max_err  <= '0;
      r_viol_cnt <= '0;
    end else if (r_s1_valid) begin
      if (w_err > r_max_err) begin
        r_max_err <= w_err;
      end
      if (w_viol) begin
        r_viol_cnt <= r_viol_cnt + (IN_W+1)'(1);
      end
    end
  end

  assign max_err_o  = r_max_err;
  assign viol_cnt_o = r_viol_cnt;

`ifdef ERR_SUM_EN
  logic [OUT_W+IN_W-1:0] r_sum_err;

  // Error sum for the mean-error figure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum_err <= '0;
    end else if (w_accept) begin
      r_sum_err <= '0;
    end else if (r_s1_valid) begin
      r_sum_err <= r_sum_err + (OUT_W+IN_W)'(w_err);
    end
  end

  assign sum_err_o = r_sum_err;
`endif

endmodule

// File: tb/tb_approx_mul_err_sweeper.sv
// Directed bench for approx_mul_err_sweeper: table of approximate-circuit
// models with hand-computed results, plus reset and held-start sequences.
module tb_approx_mul_err_sweeper;
  import approx_eval_pkg::*;

  localparam int IN_W  = 4;
  localparam int OUT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [IN_W-1:0]  vec_o;
  logic [OUT_W-1:0] approx_i;
  logic             busy_o;
  logic             done_o;
  logic [OUT_W-1:0] max_err_o;
  logic [IN_W:0]    viol_cnt_o;
  logic             pass_o;
`ifdef ERR_SUM_EN
  logic [OUT_W+IN_W-1:0] sum_err_o;
`endif

  int mode;
  int n_checks = 0;
  int n_errors = 0;

  approx_mul_err_sweeper #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vec_o      (vec_o),
    .approx_i   (approx_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .max_err_o  (max_err_o),
    .viol_cnt_o (viol_cnt_o),
    .pass_o     (pass_o)
`ifdef ERR_SUM_EN
    ,
    .sum_err_o  (sum_err_o)
`endif
  );

  always #5 clk = ~clk;

  // Approximate-circuit models: 0 exact, 1 stuck-at-zero, 2 saturating +5, 3 constant 15.
  always_comb begin
    int p;
    p = int'(vec_o[1:0]) * int'(vec_o[3:2]);
    case (mode)
      0:       approx_i = OUT_W'(p);
      1:       approx_i = 4'd0;
      2:       approx_i = (p + 5 > 15) ? 4'd15 : OUT_W'(p + 5);
      3:       approx_i = 4'd15;
      default: approx_i = 4'd0;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start, check the first issued cycle, then count edges until done.
  task automatic run_sweep(output int lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_vec0", int'(vec_o), 0);
    check("accept_busy", int'(busy_o), 1);
    check("accept_done_clr", int'(done_o), 0);
    check("accept_max_clr", int'(max_err_o), 0);
    lat = 0;
    while (!done_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    int   mode;
    int   exp_max;
    int   exp_viol;
    int   exp_pass;
    int   exp_sum;
  } vec_rec_t;

  vec_rec_t tbl[4];

  initial begin
    int lat;
    int n;
    err_t exp_err;

    tbl[0] = '{mode: 0, exp_max: 0,  exp_viol: 0,  exp_pass: 1, exp_sum: 0};
    tbl[1] = '{mode: 1, exp_max: 9,  exp_viol: 3,  exp_pass: 0, exp_sum: 36};
    tbl[2] = '{mode: 2, exp_max: 5,  exp_viol: 0,  exp_pass: 1, exp_sum: 80};
    tbl[3] = '{mode: 3, exp_max: 15, exp_viol: 16, exp_pass: 0, exp_sum: 204};

    mode  = 0;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vec", int'(vec_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_max", int'(max_err_o), 0);
    check("rst_viol", int'(viol_cnt_o), 0);
    check("rst_pass", int'(pass_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      run_sweep(lat);
      check("latency", lat, 18);
      exp_err = err_t'(tbl[i].exp_max);
      check("max_err", int'(max_err_o), int'(exp_err));
      check("viol_cnt", int'(viol_cnt_o), tbl[i].exp_viol);
      check("pass", int'(pass_o), tbl[i].exp_pass);
      check("busy_in_done", int'(busy_o), 0);
      check("vec_nowrap", int'(vec_o), 15);
`ifdef ERR_SUM_EN
      check("sum_err", int'(sum_err_o), tbl[i].exp_sum);
`endif
      repeat (2) @(posedge clk);
      #1;
      check("done_hold", int'(done_o), 1);
    end

    // Reset in the middle of a sweep, then a fresh sweep.
    mode  = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (vec_o != 4'd7 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_vec7", int'(vec_o), 7);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_vec", int'(vec_o), 0);
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_done", int'(done_o), 0);
    check("midrst_max", int'(max_err_o), 0);
    check("midrst_viol", int'(viol_cnt_o), 0);
    check("midrst_pass", int'(pass_o), 0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_rst", int'(busy_o), 0);
    run_sweep(lat);
    check("restart_latency", lat, 18);
    check("restart_max", int'(max_err_o), 9);
    check("restart_viol", int'(viol_cnt_o), 3);
    check("restart_pass", int'(pass_o), 0);

    // Start held high across a whole sweep and into DONE.
    mode  = 2;
    start = 1'b1;
    @(posedge clk); #1;
    check("held_accept_done", int'(done_o), 0);
    check("held_accept_vec", int'(vec_o), 0);
    lat = 0;
    while (!done_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("held_latency", lat, 18);
    check("held_max", int'(max_err_o), 5);
    @(posedge clk); #1;
    check("resweep_done_low", int'(done_o), 0);
    check("resweep_max_clr", int'(max_err_o), 0);
    check("resweep_busy", int'(busy_o), 1);
    n = 0;
    while (!done_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_low_cycles", n, 18);
    check("resweep_max", int'(max_err_o), 5);
    check("resweep_viol", int'(viol_cnt_o), 0);
    check("resweep_pass", int'(pass_o), 1);
    start = 1'b0;
    @(posedge clk); #1;
    check("final_done_hold", int'(done_o), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
